// File: rtl/hilo_div_ctrl_pkg.sv
// hilo_div_ctrl_pkg: opcodes, state encoding and op decode
// helpers shared by the HI/LO divide sequencer and its users.
package hilo_div_ctrl_pkg;

   localparam int CPU_REG_WIDTH = 32;

   typedef enum logic [2:0] {
      OP_DIV  = 3'd0,
      OP_DIVU = 3'd1,
      OP_MTHI = 3'd2,
      OP_MTLO = 3'd3,
      OP_MFHI = 3'd4,
      OP_MFLO = 3'd5
   } hilo_op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2
   } hilo_state_e;

   function automatic logic op_is_div(logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_is_mthi(logic [2:0] op);
      return op == OP_MTHI;
   endfunction

   function automatic logic op_is_mtlo(logic [2:0] op);
      return op == OP_MTLO;
   endfunction

   function automatic logic op_is_mfhi(logic [2:0] op);
      return op == OP_MFHI;
   endfunction

   function automatic logic op_is_mflo(logic [2:0] op);
      return op == OP_MFLO;
   endfunction

endpackage

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: owns HI/LO, sequences the external long
// divider and stalls execute while a division is in flight.
module hilo_div_ctrl
   import hilo_div_ctrl_pkg::*;
#(
   parameter int WIDTH = CPU_REG_WIDTH
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               op_valid,
   input  logic [2:0]         op,
   input  logic [WIDTH-1:0]   rs,
   input  logic [WIDTH-1:0]   rt,
   input  logic               cancel,
   output logic               stall,
   output logic [WIDTH-1:0]   rd_data,
   output logic               div_start,
   output logic               div_signd,
   output logic [WIDTH-1:0]   div_dividend,
   output logic [WIDTH-1:0]   div_divider,
   input  logic               div_ready,
   input  logic [2*WIDTH-1:0] div_remquot
);

   hilo_state_e      state;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   logic idle;
   logic take;
   logic is_div;
   logic is_mthi;
   logic is_mtlo;
   logic is_mfhi;
   logic is_mflo;

   assign idle    = (state == S_IDLE);
   assign take    = op_valid & ~cancel & idle;
   assign stall   = op_valid & ~cancel & ~idle;

   assign is_div  = op_is_div(op);
   assign is_mthi = op_is_mthi(op);
   assign is_mtlo = op_is_mtlo(op);
   assign is_mfhi = op_is_mfhi(op);
   assign is_mflo = op_is_mflo(op);

   always_comb begin
      rd_data = '0;
      if (take) begin
         unique case (1'b1)
            is_mfhi: rd_data = hi;
            is_mflo: rd_data = lo;
            default: rd_data = '0;
         endcase
      end
   end

   // Operand latches stay put until the next accepted DIV so the
   // divider's sign correction sees stable inputs throughout.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state        <= S_IDLE;
         hi           <= '0;
         lo           <= '0;
         div_start    <= 1'b0;
         div_signd    <= 1'b0;
         div_dividend <= '0;
         div_divider  <= '0;
      end else begin
         div_start <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (take) begin
                  unique case (1'b1)
                     is_div: begin
                        div_dividend <= rs;
                        div_divider  <= rt;
                        div_signd    <= (op == OP_DIV);
                        div_start    <= 1'b1;
                        state        <= S_START;
                     end
                     is_mthi: hi <= rs;
                     is_mtlo: lo <= rs;
                     default: ;
                  endcase
               end
            end
            S_START: begin
               state <= cancel ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
               if (cancel) begin
                  state <= S_IDLE;
               end else if (div_ready) begin
                  hi    <= div_remquot[2*WIDTH-1:WIDTH];
                  lo    <= div_remquot[WIDTH-1:0];
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
